uart_pkt_parser: RTL and testbench
==================================

UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

Interface
REQ-001 The parameter CLK_FREQ SHALL default to 50_000_000 and give the sys_clk frequency in Hz (informational only).
REQ-002 The parameter TIMEOUT_CYC SHALL default to 50_000 and give the maximum number of idle sys_clk cycles allowed between bytes of one packet.
REQ-003 Port sys_clk SHALL be an input, 1 bit wide, and be the single clock; all logic is rising-edge.
REQ-004 Port sys_rst SHALL be an input, 1 bit wide, and be the synchronous, active-high reset.
REQ-005 Port rx_data SHALL be an input, 8 bits wide, carrying the byte from the upstream UART receiver.
REQ-006 Port rx_done SHALL be an input, 1 bit wide, and pulse for one cycle when rx_data is valid.
REQ-007 Port pkt_valid SHALL be an output, 1 bit wide, and pulse for one cycle when a complete, good packet is available.
REQ-008 Port pkt_err SHALL be an output, 1 bit wide, and pulse for one cycle when a packet is rejected.
REQ-009 Port err_code SHALL be an output, 2 bits wide: 1 = tail mismatch, 2 = CRC mismatch, 3 = timeout.
REQ-010 The field outputs SHALL be: reg_func (8 bits), hs_pwm_ch (8), hs_ctrl_sta (8), duty_num (8), pulse_dessert (16), pulse_num (8) and pat (32).
REQ-011 Port busy SHALL be an output, 1 bit wide, and be high whenever the parser is not in IDLE.

Function
REQ-012 The packet SHALL be 14 bytes in this order: 0x55 header; reg_func; hs_pwm_ch; hs_ctrl_sta; duty_num; pulse_dessert MSB then LSB; pulse_num; pat MSB first (4 bytes); CRC; 0xAA tail.
REQ-013 The FSM SHALL have the states IDLE, PAYLOAD, CRC, TAIL and OUT.
REQ-014 In IDLE, an rx_done with 0x55 SHALL move the FSM to PAYLOAD and clear the byte index; any other byte SHALL be discarded with no pkt_err.
REQ-015 In PAYLOAD, each rx_done SHALL store the byte into a shadow register at the current index, incrementing a 4-bit index from 0 to 10; after index 10 the FSM SHALL go to CRC.
REQ-016 In CRC, rx_done SHALL latch the received CRC and move the FSM to TAIL.
REQ-017 In TAIL, on rx_done:
- a byte other than 0xAA SHALL produce pkt_err with err_code=1 and a return to IDLE;
- 0xAA with a CRC mismatch SHALL produce pkt_err with err_code=2 and a return to IDLE;
- otherwise the FSM SHALL go to OUT.
REQ-018 In OUT, the shadow registers SHALL be copied to the field outputs, pkt_valid SHALL be high for exactly that cycle, and the FSM SHALL return to IDLE.
REQ-019 pkt_valid SHALL rise exactly 1 cycle after the tail-byte rx_done.
REQ-020 The field outputs SHALL hold their values until the next pkt_valid and SHALL never change on an error.
REQ-021 An inter-byte counter SHALL clear on every rx_done and increment otherwise while the FSM is outside IDLE and OUT.
REQ-022 When the inter-byte counter reaches TIMEOUT_CYC-1, the parser SHALL produce pkt_err with err_code=3 and return to IDLE; a timeout and an rx_done in the same cycle SHALL be resolved in favour of rx_done.
REQ-023 A 0x55 received mid-packet SHALL be treated as data, with no resynchronisation.
REQ-024 rx_done asserted during OUT SHALL be processed as an IDLE byte, so back-to-back packets are not lost.
REQ-025 pkt_valid and pkt_err SHALL never be high in the same cycle.

Reset
REQ-026 While sys_rst is high at a clock edge, the FSM SHALL enter IDLE and the index, counter, shadow registers and all outputs SHALL become 0.
REQ-027 A reset arriving mid-packet SHALL abandon the packet silently, with no pkt_err.

Configuration
REQ-028 With PKT_CRC_CHECK_EN defined, the parser SHALL compute CRC-8 (polynomial 0x07, init 0x00, no reflection, no final XOR) over the 11 payload bytes, updated byte-serially on each PAYLOAD rx_done, and compare it in TAIL.
REQ-029 Without PKT_CRC_CHECK_EN, the CRC byte SHALL be accepted and ignored, and err_code=2 SHALL never occur.

Structure
REQ-030 Package dds_pkt_pkg SHALL hold the PKT_HEAD=0x55, PKT_TAIL=0xAA, PAYLOAD_LEN=11, CRC_POLY=0x07 constants, the FSM state enum, and the err_code enum.
REQ-031 The sub-module pkt_crc8 SHALL implement a combinational single-byte CRC-8 update (crc_in, byte_in -> crc_out), instantiated only under PKT_CRC_CHECK_EN.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Good packet: 55 01 01 01 03 00 44 00 00 00 00 FF, model-computed CRC, AA -> one pkt_valid 1 cycle after the AA rx_done; reg_func=01, duty_num=03, pulse_dessert=0x0044, pat=0x000000FF.
- Bad tail: same packet ending 0xAB -> pkt_err with err_code=1; field outputs unchanged from the previous packet.
- Bad CRC (CRC_CHECK_EN defined): CRC byte 0x1C with a mismatched payload -> err_code=2; without the macro, the same stimulus -> pkt_valid.
- Timeout: TIMEOUT_CYC=100; send 55 02 then stall 100 cycles -> pkt_err with err_code=3 on the 100th idle cycle; busy falls.
- Junk then packet: 00 AA 55 followed by a full good packet -> no error, one pkt_valid.
- Reset mid-packet: sys_rst after 5 bytes -> all outputs 0, no pkt_err; the following good packet is accepted.

Source files
------------

// File: rtl/dds_pkt_pkg.sv
// Shared definitions for the UART packet parser.
//
// Contents:
//   PKT_HEAD / PKT_TAIL : framing bytes (0x55 header, 0xAA tail)
//   PAYLOAD_LEN         : number of payload bytes between header and CRC (11)
//   CRC_POLY            : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   state_t             : parser FSM states
//   err_code_t          : values reported on err_code when pkt_err pulses
package dds_pkt_pkg;

    localparam logic [7:0] PKT_HEAD    = 8'h55;
    localparam logic [7:0] PKT_TAIL    = 8'hAA;
    localparam int         PAYLOAD_LEN = 11;
    localparam logic [7:0] CRC_POLY    = 8'h07;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAYLOAD = 3'd1,
        CRC     = 3'd2,
        TAIL    = 3'd3,
        OUT     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TAIL    = 2'd1,
        ERR_CRC     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

endpackage

// File: rtl/pkt_crc8.sv
// Combinational single-byte CRC-8 update (MSB first, no reflection).
//
// Ports:
//   crc_in  [7:0] : running CRC before this byte
//   byte_in [7:0] : byte to fold in
//   crc_out [7:0] : running CRC after this byte
module pkt_crc8
    import dds_pkt_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    // With a zero initial value and no reflection, XOR-ing the whole byte in
    // up front and then doing eight shift steps equals the bit-serial form.
    always_comb begin
        c = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ CRC_POLY;
            else      c = {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/uart_pkt_parser.sv
// Parser for 14-byte control packets arriving byte-by-byte from a UART
// receiver:  55 | 11 payload bytes | CRC | AA
//
// Configuration macro:
//   PKT_CRC_CHECK_EN : when defined, a CRC-8 (poly 0x07, init 0) over the
//                      payload is accumulated and checked against the CRC
//                      byte; when undefined the CRC byte is accepted and
//                      ignored.
//
// Parameters:
//   CLK_FREQ    : sys_clk frequency in Hz (informational)
//   TIMEOUT_CYC : max idle cycles allowed between bytes of one packet
//
// Ports:
//   sys_clk, sys_rst     : clock, synchronous active-high reset
//   rx_data, rx_done     : byte from the UART receiver and its 1-cycle strobe
//   pkt_valid            : 1-cycle pulse, field outputs hold a new good packet
//   pkt_err, err_code    : 1-cycle pulse on rejection, 1=tail 2=CRC 3=timeout
//   reg_func .. pat      : decoded packet fields, held until next pkt_valid
//   busy                 : parser is inside a packet (not IDLE)
module uart_pkt_parser
    import dds_pkt_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int TIMEOUT_CYC = 50_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        pkt_valid,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic [7:0]  reg_func,
    output logic [7:0]  hs_pwm_ch,
    output logic [7:0]  hs_ctrl_sta,
    output logic [7:0]  duty_num,
    output logic [15:0] pulse_dessert,
    output logic [7:0]  pulse_num,
    output logic [31:0] pat,
    output logic        busy
);

    // CLK_FREQ does not affect the logic; it only guards against a
    // nonsensical configuration collapsing the counter width.
    localparam int CNT_W = (CLK_FREQ > 0 && TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       IDX_LAST = 4'(PAYLOAD_LEN - 1);

    state_t           state_q;
    logic [3:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       shadow_q [PAYLOAD_LEN];

    logic             pkt_valid_q;
    logic             pkt_err_q;
    err_code_t        err_code_q;
    logic [7:0]       reg_func_q;
    logic [7:0]       hs_pwm_ch_q;
    logic [7:0]       hs_ctrl_sta_q;
    logic [7:0]       duty_num_q;
    logic [15:0]      pulse_dessert_q;
    logic [7:0]       pulse_num_q;
    logic [31:0]      pat_q;

    logic             in_pkt;
    logic             timeout;
    logic             crc_ok;

`ifdef PKT_CRC_CHECK_EN
    logic [7:0] crc_q;
    logic [7:0] rx_crc_q;
    logic [7:0] crc_d;

    pkt_crc8 u_crc8 (
        .crc_in  (crc_q),
        .byte_in (rx_data),
        .crc_out (crc_d)
    );

    assign crc_ok = (crc_q == rx_crc_q);
`else
    assign crc_ok = 1'b1;
`endif

    assign in_pkt = (state_q == PAYLOAD) || (state_q == CRC) || (state_q == TAIL);
    assign cnt_d  = cnt_q + CNT_W'(1);
    // Fires on the edge where the counter would reach TIMEOUT_CYC-1, so the
    // registered pkt_err is visible on the TIMEOUT_CYC-th idle cycle. A byte
    // arriving in the same cycle wins.
    assign timeout = in_pkt && !rx_done && (cnt_d == CNT_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            cnt_q           <= '0;
            for (int i = 0; i < PAYLOAD_LEN; i++) shadow_q[i] <= '0;
            pkt_valid_q     <= 1'b0;
            pkt_err_q       <= 1'b0;
            err_code_q      <= ERR_NONE;
            reg_func_q      <= '0;
            hs_pwm_ch_q     <= '0;
            hs_ctrl_sta_q   <= '0;
            duty_num_q      <= '0;
            pulse_dessert_q <= '0;
            pulse_num_q     <= '0;
            pat_q           <= '0;
`ifdef PKT_CRC_CHECK_EN
            crc_q           <= '0;
            rx_crc_q        <= '0;
`endif
        end else begin
            pkt_valid_q <= 1'b0;
            pkt_err_q   <= 1'b0;

            if (rx_done || !in_pkt) cnt_q <= '0;
            else                    cnt_q <= cnt_d;

            if (timeout) begin
                pkt_err_q  <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
                state_q    <= IDLE;
            end else begin
                unique case (state_q)
                    // OUT lasts one cycle and behaves like IDLE so a header
                    // arriving right after a tail byte is not dropped.
                    IDLE, OUT: begin
                        state_q <= IDLE;
                        if (rx_done && rx_data == PKT_HEAD) begin
                            state_q <= PAYLOAD;
                            idx_q   <= '0;
`ifdef PKT_CRC_CHECK_EN
                            crc_q   <= '0;
`endif
                        end
                    end
                    PAYLOAD: begin
                        if (rx_done) begin
                            shadow_q[idx_q] <= rx_data;
`ifdef PKT_CRC_CHECK_EN
                            crc_q <= crc_d;
`endif
                            if (idx_q == IDX_LAST) state_q <= CRC;
                            else                   idx_q   <= idx_q + 4'd1;
                        end
                    end
                    CRC: begin
                        if (rx_done) begin
`ifdef PKT_CRC_CHECK_EN
                            rx_crc_q <= rx_data;
`endif
                            state_q <= TAIL;
                        end
                    end
                    TAIL: begin
                        if (rx_done) begin
                            if (rx_data != PKT_TAIL) begin
                                pkt_err_q  <= 1'b1;
                                err_code_q <= ERR_TAIL;
                                state_q    <= IDLE;
                            end else if (!crc_ok) begin
                                pkt_err_q  <= 1'b1;
                                err_code_q <= ERR_CRC;
                                state_q    <= IDLE;
                            end else begin
                                // Fields and pkt_valid are loaded on entry
                                // to OUT so they are visible during OUT,
                                // one cycle after the tail strobe.
                                state_q         <= OUT;
                                pkt_valid_q     <= 1'b1;
                                reg_func_q      <= shadow_q[0];
                                hs_pwm_ch_q     <= shadow_q[1];
                                hs_ctrl_sta_q   <= shadow_q[2];
                                duty_num_q      <= shadow_q[3];
                                pulse_dessert_q <= {shadow_q[4], shadow_q[5]};
                                pulse_num_q     <= shadow_q[6];
                                pat_q           <= {shadow_q[7], shadow_q[8],
                                                    shadow_q[9], shadow_q[10]};
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pkt_valid     = pkt_valid_q;
    assign pkt_err       = pkt_err_q;
    assign err_code      = err_code_q;
    assign reg_func      = reg_func_q;
    assign hs_pwm_ch     = hs_pwm_ch_q;
    assign hs_ctrl_sta   = hs_ctrl_sta_q;
    assign duty_num      = duty_num_q;
    assign pulse_dessert = pulse_dessert_q;
    assign pulse_num     = pulse_num_q;
    assign pat           = pat_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_pkt_parser.sv
module tb_uart_pkt_parser;

    localparam int TMO = 100;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        pkt_valid;
    logic        pkt_err;
    logic [1:0]  err_code;
    logic [7:0]  reg_func;
    logic [7:0]  hs_pwm_ch;
    logic [7:0]  hs_ctrl_sta;
    logic [7:0]  duty_num;
    logic [15:0] pulse_dessert;
    logic [7:0]  pulse_num;
    logic [31:0] pat;
    logic        busy;

    uart_pkt_parser #(
        .CLK_FREQ    (50_000_000),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .pkt_valid     (pkt_valid),
        .pkt_err       (pkt_err),
        .err_code      (err_code),
        .reg_func      (reg_func),
        .hs_pwm_ch     (hs_pwm_ch),
        .hs_ctrl_sta   (hs_ctrl_sta),
        .duty_num      (duty_num),
        .pulse_dessert (pulse_dessert),
        .pulse_num     (pulse_num),
        .pat           (pat),
        .busy          (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  rf;
        logic [7:0]  ch;
        logic [7:0]  sta;
        logic [7:0]  duty;
        logic [15:0] pd;
        logic [7:0]  pn;
        logic [31:0] pat;
    } fields_t;

    typedef struct packed {
        logic        is_err;
        logic [1:0]  code;
        logic [31:0] cyc;
        fields_t     f;
    } exp_t;

    exp_t    sb [$];
    int      total = 0;
    int      bad   = 0;
    fields_t cur_f = '0;

    // Directed packets (payload only) with hand-decoded expected fields.
    logic [7:0] P0 [11] = '{8'h01, 8'h01, 8'h01, 8'h03, 8'h00, 8'h44,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic [7:0] P1 [11] = '{8'h02, 8'h05, 8'h06, 8'h07, 8'h12, 8'h34,
                            8'h09, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    // Contains 55 and AA as data: must not resynchronise.
    logic [7:0] P2 [11] = '{8'h55, 8'hAA, 8'h10, 8'h20, 8'h30, 8'h40,
                            8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
    fields_t F0 = '{rf:8'h01, ch:8'h01, sta:8'h01, duty:8'h03, pd:16'h0044,
                    pn:8'h00, pat:32'h000000FF};
    fields_t F1 = '{rf:8'h02, ch:8'h05, sta:8'h06, duty:8'h07, pd:16'h1234,
                    pn:8'h09, pat:32'hDEADBEEF};
    fields_t F2 = '{rf:8'h55, ch:8'hAA, sta:8'h10, duty:8'h20, pd:16'h3040,
                    pn:8'h50, pat:32'h60708090};

    // Bit-serial CRC-8, poly 0x07, init 0, MSB first.
    function automatic logic [7:0] crc8_model(input logic [7:0] pl [11]);
        logic [7:0] crc = 8'h00;
        logic       fb;
        for (int n = 0; n < 11; n++) begin
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[7] ^ pl[n][b];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return crc;
    endfunction

    function automatic fields_t dut_fields();
        fields_t f;
        f.rf   = reg_func;
        f.ch   = hs_pwm_ch;
        f.sta  = hs_ctrl_sta;
        f.duty = duty_num;
        f.pd   = pulse_dessert;
        f.pn   = pulse_num;
        f.pat  = pat;
        return f;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_pkt_valid"}, pkt_valid, 1'b0);
        check({tag, "_pkt_err"},   pkt_err,   1'b0);
        check({tag, "_err_code"},  err_code,  2'd0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_fields"},    dut_fields(), '0);
    endtask

    // Scoreboard monitor: every output pulse must match the oldest expectation.
    always @(negedge sys_clk) begin
        if (!sys_rst && (pkt_valid || pkt_err)) begin
            exp_t e;
            check("valid_err_exclusive", pkt_valid & pkt_err, 1'b0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: valid=%0b err=%0b code=%0d at cyc %0d, nothing expected",
                         pkt_valid, pkt_err, err_code, cyc);
            end else begin
                e = sb.pop_front();
                check("kind_is_err", pkt_err, e.is_err);
                check("event_cycle", cyc, e.cyc);
                if (e.is_err) check("err_code", err_code, e.code);
                check("fields", dut_fields(), e.f);
            end
        end
    end

    // Called at a negedge; returns at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge sys_clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic send_pkt(input logic [7:0] pl [11], input logic [7:0] crc,
                            input logic [7:0] tail, input logic is_err,
                            input logic [1:0] code, input fields_t f, input int gap_after);
        exp_t e;
        send_byte(8'h55, 1);
        for (int i = 0; i < 11; i++) send_byte(pl[i], 1);
        send_byte(crc, 1);
        rx_data  = tail;
        rx_done  = 1'b1;
        e.is_err = is_err;
        e.code   = code;
        e.cyc    = cyc + 1;
        e.f      = f;
        sb.push_back(e);
        @(negedge sys_clk);
        rx_done = 1'b0;
        repeat (gap_after) @(negedge sys_clk);
    endtask

    initial begin
        logic crc_chk;
        exp_t e;
`ifdef PKT_CRC_CHECK_EN
        crc_chk = 1'b1;
`else
        crc_chk = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge sys_clk);
        check_idle_zero("reset");
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Good packet
        send_pkt(P0, crc8_model(P0), 8'hAA, 1'b0, 2'd0, F0, 3);
        cur_f = F0;
        check("good_busy_after", busy, 1'b0);

        // Bad tail: fields must keep the previous packet
        send_pkt(P0, crc8_model(P0), 8'hAB, 1'b1, 2'd1, cur_f, 3);

        // Bad CRC byte 0x1C
        if (crc_chk && crc8_model(P1) != 8'h1C) begin
            send_pkt(P1, 8'h1C, 8'hAA, 1'b1, 2'd2, cur_f, 3);
        end else begin
            send_pkt(P1, 8'h1C, 8'hAA, 1'b0, 2'd0, F1, 3);
            cur_f = F1;
        end

        // Timeout: 55 02 then stall
        send_byte(8'h55, 1);
        rx_data  = 8'h02;
        rx_done  = 1'b1;
        e.is_err = 1'b1;
        e.code   = 2'd3;
        e.cyc    = cyc + TMO;
        e.f      = cur_f;
        sb.push_back(e);
        @(negedge sys_clk);
        rx_done = 1'b0;
        repeat (50) @(negedge sys_clk);
        check("busy_mid_stall", busy, 1'b1);
        repeat (TMO) @(negedge sys_clk);
        check("busy_after_timeout", busy, 1'b0);

        // Junk bytes, then a packet whose tail is followed immediately by
        // the next header (back-to-back through OUT)
        send_byte(8'h00, 1);
        send_byte(8'hAA, 1);
        check("junk_not_busy", busy, 1'b0);
        send_pkt(P2, crc8_model(P2), 8'hAA, 1'b0, 2'd0, F2, 0);
        cur_f = F2;
        send_pkt(P0, crc8_model(P0), 8'hAA, 1'b0, 2'd0, F0, 3);
        cur_f = F0;

        // Reset mid-packet after 5 bytes
        send_byte(8'h55, 1);
        send_byte(8'h01, 1);
        send_byte(8'h01, 1);
        send_byte(8'h01, 1);
        send_byte(8'h03, 1);
        check("busy_before_reset", busy, 1'b1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check_idle_zero("midreset");
        cur_f = '0;
        repeat (3) @(negedge sys_clk);

        // Packet accepted after reset
        send_pkt(P0, crc8_model(P0), 8'hAA, 1'b0, 2'd0, F0, 3);
        cur_f = F0;

        repeat (20) @(negedge sys_clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
